// File: rtl/enc_pkg.sv
// Shared types and helpers for the rotary encoder position accumulator.
package enc_pkg;

   localparam int unsigned MULT_W = 3;

   localparam logic [MULT_W-1:0] MULT_1 = MULT_W'(1);
   localparam logic [MULT_W-1:0] MULT_2 = MULT_W'(2);
   localparam logic [MULT_W-1:0] MULT_4 = MULT_W'(4);

   typedef enum logic {
      CW  = 1'b0,
      CCW = 1'b1
   } dir_e;

   // Saturate a wide signed value into [lo, hi].
   function automatic longint clip(input longint v, input longint lo, input longint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/enc_acc_if.sv
// Register-side bus of the encoder accumulator: decoder count in, position/change out.
interface enc_acc_if #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned ACC_W = 16
);
   logic        [CNT_W-1:0] cnt;
   logic                    wr;
   logic signed [ACC_W-1:0] data;
   logic                    rd;
   logic signed [ACC_W-1:0] acc;
   logic                    chg;

   modport master (output cnt, wr, data, rd, input acc, chg);
   modport slave  (input cnt, wr, data, rd, output acc, chg);
endinterface

// File: rtl/enc_vel.sv
// Velocity estimator: ticks elapsed since the last step pick the step multiplier.
module enc_vel
   import enc_pkg::*;
#(
   parameter int unsigned PRE_W  = 16,
   parameter int unsigned TMR_W  = 6,
   parameter int unsigned FAST_T = 2,
   parameter int unsigned SLOW_T = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              step,
   input  logic              sign,
   output logic [MULT_W-1:0] mult_c
);

   logic [PRE_W-1:0] pre_q;
   logic [TMR_W-1:0] tmr_q;
   dir_e             dir_q;
   dir_e             dir_c;
   logic             tick_c;

   assign dir_c  = sign ? CCW : CW;
   assign tick_c = &pre_q;

   // Timer restarts on every step and otherwise saturates at all ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pre_q <= '0;
         tmr_q <= '1;
         dir_q <= CW;
      end else if (step) begin
         pre_q <= '0;
         tmr_q <= '0;
         dir_q <= dir_c;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
         if (tick_c && (tmr_q != '1)) begin
            tmr_q <= tmr_q + TMR_W'(1);
         end
      end
   end

   // Reversals never accelerate so a direction change starts gently.
   always_comb begin
      mult_c = MULT_1;
      if (dir_c == dir_q) begin
         if (tmr_q < TMR_W'(FAST_T)) begin
            mult_c = MULT_4;
         end else if (tmr_q < TMR_W'(SLOW_T)) begin
            mult_c = MULT_2;
         end
      end
   end

endmodule

// File: rtl/enc_acc.sv
// Integrates the wrapping decoder count into a clipped signed position with acceleration.
module enc_acc
   import enc_pkg::*;
#(
   parameter int unsigned CNT_W  = 2,
   parameter int unsigned ACC_W  = 16,
   parameter int          MIN_V  = -32768,
   parameter int          MAX_V  = 32767,
   parameter int          RST_V  = 0,
   parameter int unsigned PRE_W  = 16,
   parameter int unsigned TMR_W  = 6,
   parameter int unsigned FAST_T = 2,
   parameter int unsigned SLOW_T = 8
) (
   input  logic     clk_i,
   input  logic     rst_i,
   enc_acc_if.slave bus
);

   localparam int unsigned INC_W = CNT_W + 3;
   localparam int unsigned SUM_W = ACC_W + 4;
   localparam longint      MIN_L = longint'(MIN_V);
   localparam longint      MAX_L = longint'(MAX_V);

   logic        [CNT_W-1:0]  cnt_q;
   logic signed [CNT_W-1:0]  delta_c;
   logic                     step_c;
   logic        [MULT_W-1:0] mult_c;
   logic signed [INC_W-1:0]  inc_c;
   logic signed [SUM_W-1:0]  sum_c;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d_c;
   logic                     chg_q;
   logic                     chg_d_c;

   // Modulo difference against the last seen count; the decoder is never cleared.
   assign delta_c = $signed(bus.cnt - cnt_q);
   assign step_c  = (delta_c != '0);

   enc_vel #(
      .PRE_W  (PRE_W),
      .TMR_W  (TMR_W),
      .FAST_T (FAST_T),
      .SLOW_T (SLOW_T)
   ) u_vel (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .step   (step_c),
      .sign   (delta_c[CNT_W-1]),
      .mult_c (mult_c)
   );

   assign inc_c = INC_W'(delta_c) * $signed(INC_W'(mult_c));
   assign sum_c = SUM_W'(acc_q) + SUM_W'(inc_c);

   // A load overrides any step and never flags a change.
   always_comb begin
      acc_d_c = acc_q;
      chg_d_c = chg_q;
      if (bus.wr) begin
         acc_d_c = ACC_W'(clip(longint'(bus.data), MIN_L, MAX_L));
         if (bus.rd) begin
            chg_d_c = 1'b0;
         end
      end else begin
         if (step_c) begin
            acc_d_c = ACC_W'(clip(longint'(sum_c), MIN_L, MAX_L));
         end
         if (acc_d_c != acc_q) begin
            chg_d_c = 1'b1;
         end else if (bus.rd) begin
            chg_d_c = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         acc_q <= ACC_W'(RST_V);
         chg_q <= 1'b0;
      end else begin
         cnt_q <= bus.cnt;
         acc_q <= acc_d_c;
         chg_q <= chg_d_c;
      end
   end

   assign bus.acc = acc_q;
   assign bus.chg = chg_q;

endmodule
